// File: rtl/knn_seq_ctrl.sv
// Phase sequencer for the KNN classifier datapath: IDLE -> LOAD -> SORT -> VOTE,
// with start/done handshake, stall, abort, back-to-back mode and a run counter.
module knn_seq_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int NUM_SAMPLES = 128,
  parameter int SORT_CYCLES = 4,
  parameter int VOTE_CYCLES = 3,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               abort,
  input  logic               continuous,
  output logic [1:0]         state,
  output logic [ADDR_W-1:0]  address,
  output logic               addr_valid,
  output logic               phase_last,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] frame_count
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | one training-sample address per unstalled cycle
  // SORT  | k-nearest selection
  // VOTE  | majority vote; last cycle loops to LOAD or returns to IDLE
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_SORT = 2'b10;
  localparam logic [1:0] S_VOTE = 2'b11;

  localparam int W_LOAD = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int W_SORT = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
  localparam int W_VOTE = (VOTE_CYCLES > 1) ? $clog2(VOTE_CYCLES) : 1;
  localparam int W_SV   = (W_SORT > W_VOTE) ? W_SORT : W_VOTE;
  localparam int W_LS   = (W_LOAD > W_SV) ? W_LOAD : W_SV;
  localparam int CNT_W  = (ADDR_W > W_LS) ? ADDR_W : W_LS;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] SORT_LAST = CNT_W'(SORT_CYCLES - 1);
  localparam logic [CNT_W-1:0] VOTE_LAST = CNT_W'(VOTE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             at_last;

  always_comb begin
    last_cnt = '0;
    case (state)
      S_LOAD:  last_cnt = LOAD_LAST;
      S_SORT:  last_cnt = SORT_LAST;
      S_VOTE:  last_cnt = VOTE_LAST;
      default: last_cnt = '0;
    endcase
  end

  assign at_last = (cnt == last_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            if (start) state <= S_LOAD;
          end
          default: begin
            if (!stall) begin
              if (at_last) begin
                cnt <= '0;
                case (state)
                  S_LOAD: state <= S_SORT;
                  S_SORT: state <= S_VOTE;
                  default: begin
                    state       <= continuous ? S_LOAD : S_IDLE;
                    done        <= 1'b1;
                    frame_count <= frame_count + COUNT_W'(1);
                  end
                endcase
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // Handshake outputs are qualified by the live stall input so the datapath
  // never consumes a frozen address twice.
  assign busy       = (state != S_IDLE);
  assign address    = (state == S_LOAD) ? cnt[ADDR_W-1:0] : '0;
  assign addr_valid = (state == S_LOAD) && !stall;
  assign phase_last = busy && !stall && at_last;

endmodule
